ppd_oup_fmt: RTL and testbench
==============================

Name: ppd_oup_fmt

Overview:
- Output stage placed directly downstream of the polyphase decimation filter.
- Detects each new filter result from the filter's slow-clock pulse and captures the full-precision signed word.
- Rounds or truncates, then saturates, the word to a narrower output width.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the consumer, with sticky saturation and overflow flags.

Parameters:
- gp_idata_width, 25, input width; equals the filter's output width.
- gp_odata_width, 16, output sample width after saturation.
- gp_shift, 9, number of LSBs dropped; must satisfy 1 <= gp_shift < gp_idata_width.
- gp_round, 1, 1 = round half up (add 2^(gp_shift-1) before shifting); 0 = truncate (floor).
- gp_fifo_depth, 4, FIFO entries; power of two, >= 2.

Ports:
- i_clk  input  1  rising-edge clock; same clock that drives the filter's commutator.
- i_rst_an  input  1  reset, synchronous, active-low.
- i_ena  input  1  synchronous active-high enable; gates capture only.
- i_data  input  gp_idata_width  signed filter result.
- i_sclk  input  1  filter slow-clock pulse; a new i_data is valid at each rising edge of i_sclk.
- i_ready  input  1  consumer accepts o_data when o_valid and i_ready are both high.
- i_clr  input  1  clears o_sat and o_ovf.
- o_data  output  gp_odata_width  signed formatted sample, FIFO head.
- o_valid  output  1  FIFO not empty.
- o_level  output  clog2(gp_fifo_depth)+1  FIFO occupancy.
- o_sat  output  1  sticky flag: at least one sample was saturated.
- o_ovf  output  1  sticky flag: at least one sample was dropped because the FIFO was full.

Behaviour:
- Reset:
  - Applies on the rising i_clk edge at which i_rst_an = 0.
  - All registers clear: sclk_q, the stage-1 and stage-2 data and valid bits, FIFO pointers, flags.
  - o_data = 0, o_valid = 0, o_level = 0, o_sat = 0, o_ovf = 0.
  - Reset mid-operation discards all in-flight and buffered samples. No pop is reported in that cycle.
- Edge detect:
  - sclk_q registers i_sclk every cycle, regardless of i_ena.
  - stb = i_sclk & ~sclk_q & i_ena.
  - i_sclk held high for several cycles produces one stb only.
- Stage 1, on a clock edge with stb = 1:
  - Computes r = (sext(i_data, +1) + (gp_round ? 2^(gp_shift-1) : 0)) >>> gp_shift.
  - The shift is arithmetic; r has width gp_idata_width+1-gp_shift.
  - Sets v1 = 1; otherwise v1 = 0.
- Stage 2, every edge:
  - If r > 2^(gp_odata_width-1)-1, d2 = the positive limit and sat2 = 1.
  - If r < -2^(gp_odata_width-1), d2 = the negative limit and sat2 = 1.
  - Otherwise d2 = r and sat2 = 0.
  - v2 = v1.
- FIFO write:
  - push = v2.
  - If the FIFO is full and no pop occurs in the same cycle, the sample is dropped and o_ovf sets.
  - Push and pop in the same cycle when full: both take effect, level unchanged, no overflow.
- FIFO read:
  - pop = o_valid & i_ready.
  - Pop when empty is ignored. There is no bypass: push and pop in the same cycle when empty leave level = 1 and o_valid = 1 on the next cycle.
  - o_data is the registered FIFO head. It is 0 when the FIFO has never been written since reset; otherwise it holds the last-read value while empty.
- Latency:
  - Stage 1 loads on the detecting edge E0, stage 2 loads on E1, the FIFO is written on E2.
  - o_valid is high after E2 when the FIFO was empty.
  - Throughput is one sample per cycle, which always exceeds the decimated rate.
- Flags:
  - o_sat sets when a sample with sat2 = 1 is written, including a sample that is dropped.
  - Both flags clear on a clock edge with i_clr = 1.
  - If a set condition and i_clr occur in the same cycle, set wins.
- Pointers:
  - Read and write pointers are clog2(depth)+1 bits and wrap modulo 2*depth.
  - Full = MSBs differ and the remaining bits are equal; empty = pointers equal.

Decomposition:
- Package ppd_pkg:
  - clog2 function.
  - Ceiling-divide function matching the filter's output-width formula, so gp_idata_width can be derived at integration.
  - Rounding-constant function.
  - Saturation-limit constants.
- One sub-module, ppd_sync_fifo: parameterised width and depth; ports push, pop, din, dout, full, empty, level; synchronous active-low reset.

Test Plan:
- Round path (default parameters): i_data = 1280 -> o_data = 3; i_data = -1280 -> o_data = -2; i_data = 255 -> 0; i_data = 256 -> 1. o_sat stays 0.
- Truncate path (gp_round = 0): i_data = 1280 -> 2; i_data = -1 -> -1. o_valid rises on the third edge after the i_sclk rising edge.
- Saturation: i_data = 16777215 -> 32767 with o_sat = 1; i_data = -16777216 -> -32768 with o_sat unchanged. i_clr pulse -> o_sat = 0.
- Overflow: i_ready = 0, five i_sclk pulses with i_data = 512, 1024, 1536, 2048, 2560 -> o_level = 4, o_ovf = 1. Raising i_ready then reads out 1, 2, 3, 4.
- Edge detect and enable: i_sclk held high for 10 cycles -> exactly one sample. Pulse with i_ena = 0 -> no sample. Full FIFO with simultaneous push and pop -> level 4, o_ovf = 0.
- Reset mid-operation: two samples buffered and one in stage 1, then i_rst_an = 0 for one edge -> o_valid = 0, o_level = 0, flags 0, and no stale sample appears afterward.

Source files
------------

// File: rtl/ppd_pkg.sv
// Shared helpers for the polyphase-decimator output formatter.
package ppd_pkg;

    // Saturation limits for the default 16-bit output sample.
    localparam longint lp_sat_max16 = 64'sd32767;
    localparam longint lp_sat_min16 = -64'sd32768;

    // Ceiling log2, used for pointer and level widths.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    // Ceiling divide, matching the filter's output-width formula so the
    // input width can be derived from filter parameters at integration.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Constant added before the shift: half an output LSB when rounding.
    function automatic longint round_const(input int unsigned shift, input bit rnd);
        if (rnd && (shift > 0)) begin
            return 64'sd1 <<< (shift - 1);
        end
        return 64'sd0;
    endfunction

    // Largest positive value of a signed word of the given width.
    function automatic longint sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value of a signed word of the given width.
    function automatic longint sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/ppd_oup_fmt_if.sv
// Valid/ready sample stream between the formatter and its consumer.
interface ppd_oup_fmt_if #(
    parameter int unsigned gp_width = 16
);
    logic [gp_width-1:0] data;
    logic                valid;
    logic                ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ppd_sync_fifo.sv
// Synchronous FIFO with a registered head word and wrap-bit pointers.
module ppd_sync_fifo
    import ppd_pkg::*;
#(
    parameter int unsigned gp_width = 16,
    parameter int unsigned gp_depth = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_an,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [gp_width-1:0]          i_din,
    output logic [gp_width-1:0]          o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [clog2(gp_depth):0]     o_level
);
    localparam int unsigned lp_aw = clog2(gp_depth);

    logic [gp_width-1:0] r_mem [gp_depth];
    logic [lp_aw:0]      r_wptr;
    logic [lp_aw:0]      r_rptr;
    logic [gp_width-1:0] r_dout;
    logic [gp_width-1:0] w_dout_d;
    logic [lp_aw:0]      w_wptr_nxt;
    logic [lp_aw:0]      w_rptr_nxt;
    logic                w_push_ok;
    logic                w_pop_ok;

    assign o_empty    = (r_wptr == r_rptr);
    assign o_full     = (r_wptr[lp_aw] != r_rptr[lp_aw]) &&
                        (r_wptr[lp_aw-1:0] == r_rptr[lp_aw-1:0]);
    assign o_level    = r_wptr - r_rptr;
    assign o_dout     = r_dout;
    assign w_pop_ok   = i_pop & ~o_empty;
    // A full FIFO still accepts a write when the same edge frees a slot.
    assign w_push_ok  = i_push & (~o_full | w_pop_ok);
    assign w_wptr_nxt = r_wptr + (lp_aw + 1)'(w_push_ok);
    assign w_rptr_nxt = r_rptr + (lp_aw + 1)'(w_pop_ok);

    // Next head word; holds the last value read once the FIFO drains.
    always_comb begin
        w_dout_d = r_dout;
        if (w_rptr_nxt != w_wptr_nxt) begin
            if (w_push_ok && (w_rptr_nxt[lp_aw-1:0] == r_wptr[lp_aw-1:0])) begin
                w_dout_d = i_din;
            end else begin
                w_dout_d = r_mem[w_rptr_nxt[lp_aw-1:0]];
            end
        end
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[lp_aw-1:0]] <= i_din;
        end
    end

    // Pointers and registered head.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_dout <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_dout <= w_dout_d;
        end
    end

endmodule

// File: rtl/ppd_oup_fmt.sv
// Formats decimated filter results: capture, round/truncate, saturate, buffer.
module ppd_oup_fmt
    import ppd_pkg::*;
#(
    parameter int unsigned gp_idata_width = 25,
    parameter int unsigned gp_odata_width = 16,
    parameter int unsigned gp_shift       = 9,
    parameter int unsigned gp_round       = 1,
    parameter int unsigned gp_fifo_depth  = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_an,
    input  logic                             i_ena,
    input  logic [gp_idata_width-1:0]        i_data,
    input  logic                             i_sclk,
    input  logic                             i_clr,
    ppd_oup_fmt_if.master                    o_if,
    output logic [clog2(gp_fifo_depth):0]    o_level,
    output logic                             o_sat,
    output logic                             o_ovf
);
    localparam int unsigned lp_rw = gp_idata_width + 1 - gp_shift;
    localparam int unsigned lp_cw = (lp_rw > gp_odata_width) ? lp_rw : gp_odata_width;
    localparam logic [gp_idata_width:0] lp_rnd =
        (gp_idata_width + 1)'(round_const(gp_shift, gp_round != 0));
    localparam logic signed [lp_cw-1:0] lp_max = lp_cw'(sat_max(gp_odata_width));
    localparam logic signed [lp_cw-1:0] lp_min = lp_cw'(sat_min(gp_odata_width));

    logic                              r_sclk_q;
    logic                              r_v1;
    logic [lp_rw-1:0]                  r_r1;
    logic                              r_v2;
    logic                              r_sat2;
    logic [gp_odata_width-1:0]         r_d2;
    logic                              r_sat;
    logic                              r_ovf;
    logic                              w_stb;
    logic signed [gp_idata_width:0]    w_sum;
    logic signed [lp_cw-1:0]           w_r_ext;
    logic                              w_full;
    logic                              w_empty;
    logic                              w_pop;
    logic                              w_drop;

    assign w_stb   = i_sclk & ~r_sclk_q & i_ena;
    // One guard bit keeps the rounding add from wrapping at full scale.
    assign w_sum   = $signed({i_data[gp_idata_width-1], i_data}) + $signed(lp_rnd);
    assign w_r_ext = lp_cw'($signed(r_r1));
    assign w_pop   = o_if.valid & o_if.ready;
    assign w_drop  = r_v2 & w_full & ~w_pop;

    assign o_if.valid = ~w_empty;
    assign o_sat      = r_sat;
    assign o_ovf      = r_ovf;

    // Slow-clock edge detect and stage 1 capture with scaling.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            r_sclk_q <= 1'b0;
            r_v1     <= 1'b0;
            r_r1     <= '0;
        end else begin
            r_sclk_q <= i_sclk;
            r_v1     <= w_stb;
            if (w_stb) begin
                r_r1 <= lp_rw'(w_sum >>> gp_shift);
            end
        end
    end

    // Stage 2 saturation to the output width.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            r_v2   <= 1'b0;
            r_sat2 <= 1'b0;
            r_d2   <= '0;
        end else begin
            r_v2 <= r_v1;
            if (w_r_ext > lp_max) begin
                r_d2   <= lp_max[gp_odata_width-1:0];
                r_sat2 <= 1'b1;
            end else if (w_r_ext < lp_min) begin
                r_d2   <= lp_min[gp_odata_width-1:0];
                r_sat2 <= 1'b1;
            end else begin
                r_d2   <= w_r_ext[gp_odata_width-1:0];
                r_sat2 <= 1'b0;
            end
        end
    end

    // Sticky flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (i_clr) begin
                r_sat <= 1'b0;
                r_ovf <= 1'b0;
            end
            if (r_v2 && r_sat2) begin
                r_sat <= 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    ppd_sync_fifo #(
        .gp_width (gp_odata_width),
        .gp_depth (gp_fifo_depth)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_push   (r_v2),
        .i_pop    (w_pop),
        .i_din    (r_d2),
        .o_dout   (o_if.data),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (o_level)
    );

endmodule

// File: tb/tb_ppd_oup_fmt.sv
// Directed bench: rounding instance plus a truncating instance on shared stimulus.
module tb_ppd_oup_fmt;

    logic        clk;
    logic        rst_an;
    logic        ena;
    logic [24:0] data;
    logic        sclk;
    logic        ready;
    logic        clr;
    logic [2:0]  level_a;
    logic        sat_a;
    logic        ovf_a;
    logic [2:0]  level_b;
    logic        sat_b;
    logic        ovf_b;
    int          n_checks;
    int          n_fail;

    ppd_oup_fmt_if #(.gp_width(16)) if_a ();
    ppd_oup_fmt_if #(.gp_width(16)) if_b ();

    assign if_a.ready = ready;
    assign if_b.ready = ready;

    ppd_oup_fmt u_dut_a (
        .i_clk    (clk),
        .i_rst_an (rst_an),
        .i_ena    (ena),
        .i_data   (data),
        .i_sclk   (sclk),
        .i_clr    (clr),
        .o_if     (if_a.master),
        .o_level  (level_a),
        .o_sat    (sat_a),
        .o_ovf    (ovf_a)
    );

    ppd_oup_fmt #(.gp_round(0)) u_dut_b (
        .i_clk    (clk),
        .i_rst_an (rst_an),
        .i_ena    (ena),
        .i_data   (data),
        .i_sclk   (sclk),
        .i_clr    (clr),
        .o_if     (if_b.master),
        .o_level  (level_b),
        .o_sat    (sat_b),
        .o_ovf    (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One i_sclk pulse: E0 then E1 have occurred on return.
    task automatic send(input logic signed [24:0] d);
        data = d;
        sclk = 1'b1;
        step();
        sclk = 1'b0;
        step();
    endtask

    task automatic pop_one();
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_an   = 1'b0;
        ena      = 1'b1;
        data     = '0;
        sclk     = 1'b0;
        ready    = 1'b0;
        clr      = 1'b0;
        step();
        step();
        chk("rst_valid", if_a.valid, 0);
        chk("rst_level", level_a, 0);
        chk("rst_sat", sat_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_data", $signed(if_a.data), 0);
        rst_an = 1'b1;
        step();

        // Latency and first round/truncate pair.
        send(25'sd1280);
        chk("trunc_lat_e1", if_b.valid, 0);
        step();
        chk("trunc_lat_e2", if_b.valid, 1);
        chk("trunc_1280", $signed(if_b.data), 2);
        chk("round_1280", $signed(if_a.data), 3);
        pop_one();
        chk("empty_after_pop", if_a.valid, 0);

        send(-25'sd1280);
        step();
        chk("round_m1280", $signed(if_a.data), -2);
        pop_one();
        send(25'sd255);
        step();
        chk("round_255", $signed(if_a.data), 0);
        pop_one();
        send(25'sd256);
        step();
        chk("round_256", $signed(if_a.data), 1);
        pop_one();
        send(-25'sd1);
        step();
        chk("trunc_m1", $signed(if_b.data), -1);
        chk("round_m1", $signed(if_a.data), 0);
        pop_one();
        chk("no_sat_yet", sat_a, 0);

        // Saturation at both ends.
        send(25'sd16777215);
        step();
        chk("sat_pos", $signed(if_a.data), 32767);
        chk("sat_flag", sat_a, 1);
        pop_one();
        send(-25'sd16777216);
        step();
        chk("sat_neg", $signed(if_a.data), -32768);
        chk("sat_flag_hold", sat_a, 1);
        pop_one();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sat_clr", sat_a, 0);

        // Overflow: fifth sample dropped.
        for (int k = 1; k <= 5; k++) begin
            send(25'(512 * k));
        end
        step();
        step();
        chk("ovf_level", level_a, 4);
        chk("ovf_flag", ovf_a, 1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_read%0d", k), $signed(if_a.data), k);
            pop_one();
        end
        chk("ovf_drained", if_a.valid, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ovf_clr", ovf_a, 0);

        // Held slow clock gives one sample; disabled pulse gives none.
        data = 25'sd1024;
        sclk = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
        end
        sclk = 1'b0;
        step();
        step();
        step();
        chk("held_level", level_a, 1);
        chk("held_data", $signed(if_a.data), 2);
        pop_one();
        ena = 1'b0;
        send(25'sd1536);
        step();
        step();
        chk("ena_off_level", level_a, 0);
        ena = 1'b1;

        // Full FIFO with push and pop on the same edge.
        for (int k = 1; k <= 4; k++) begin
            send(25'(512 * k));
        end
        step();
        step();
        chk("full_level", level_a, 4);
        send(25'sd2560);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("pp_level", level_a, 4);
        chk("pp_ovf", ovf_a, 0);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("pp_read%0d", k), $signed(if_a.data), k);
            pop_one();
        end
        chk("pp_drained", level_a, 0);

        // Reset while samples are buffered and one is in stage 1.
        send(25'sd16777215);
        send(25'sd512);
        step();
        step();
        chk("mid_level", level_a, 2);
        chk("mid_sat", sat_a, 1);
        data = 25'sd1536;
        sclk = 1'b1;
        step();
        rst_an = 1'b0;
        sclk   = 1'b0;
        step();
        rst_an = 1'b1;
        chk("mid_rst_valid", if_a.valid, 0);
        chk("mid_rst_level", level_a, 0);
        chk("mid_rst_sat", sat_a, 0);
        chk("mid_rst_ovf", ovf_a, 0);
        chk("mid_rst_data", $signed(if_a.data), 0);
        for (int k = 0; k < 4; k++) begin
            step();
        end
        chk("mid_stale_valid", if_a.valid, 0);
        chk("mid_stale_level", level_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
